dm_arbiter: RTL and testbench
=============================

# dm_arbiter

Two-master arbiter for the shared data memory port. It sits between the M-stage memory interface of the pipelined MIPS core and the single data-memory port, and lets a second word-wide master (DMA/loader) use the memory in bounded bursts. A registered ownership state machine decides who drives the port. The CPU is stalled only while the DMA owns the port, and the DMA cannot be starved indefinitely.

## Interface
Parameters:
- BURST_MAX, 4: maximum consecutive DMA beats while cpu_req is pending (1..15).
- WAIT_MAX, 8: maximum cycles a pending dma_req waits behind a busy CPU (1..15).
- DM_WORDS, 3072: memory depth in words; valid byte addresses are 0 .. 4*DM_WORDS-1.

Ports:
- Clk  in  1  clock.
- Rst  in  1  reset Rst, synchronous, active-high.
- cpu_req  in  1  M-stage has a load/store this cycle.
- cpu_wr  in  1  store.
- cpu_addr  in  32  byte address.
- cpu_wd  in  32  store data.
- cpu_op  in  3  DMOp code (word/half/byte/hu/bu, shared constant header).
- cpu_wpc  in  32  PC of the instruction, for the write log.
- cpu_rd  out  32  load data.
- cpu_stall  out  1  freeze F/D/E/M this cycle.
- dma_req  in  1  DMA beat request.
- dma_wr  in  1  write beat.
- dma_addr  in  32  byte address; bits [1:0] ignored.
- dma_wd  in  32  write data.
- dma_last  in  1  final beat of the burst.
- dma_gnt  out  1  DMA owns the port.
- dma_rd  out  32  read data.
- dma_err  out  1  beat rejected (out of range).
- dm_wr  out  1  memory write enable.
- dm_a  out  32  memory address.
- dm_wd  out  32  memory write data.
- dm_op  out  3  memory DMOp.
- dm_wpc  out  32  PC for the memory write log.
- dm_rd  in  32  memory read data (combinational).

## Operation
- States: CPU_OWN (reset state) and DMA_OWN. dma_gnt = (state == DMA_OWN), registered Moore output.
- Port mux in CPU_OWN:
  - dm_wr = cpu_req & cpu_wr; dm_a/dm_wd/dm_op/dm_wpc come from the CPU.
  - cpu_rd = dm_rd; cpu_stall = 0.
- Port mux in DMA_OWN:
  - dm_wr = dma_req & dma_wr & ~dma_err; dm_a = {dma_addr[31:2], 2'b00}; dm_op = word code; dm_wpc = 0.
  - dma_rd = dm_rd; cpu_stall = cpu_req.
- Unselected read outputs are 0.
- dma_err is combinational: dma_gnt & dma_req & (dma_addr >= 4*DM_WORDS). An erroring beat writes nothing but still counts as a beat.
- wait_cnt (4-bit):
  - in CPU_OWN, increments when dma_req & cpu_req; cleared otherwise.
  - cleared on entry to DMA_OWN.
- beat_cnt (4-bit):
  - in DMA_OWN, increments on each dma_req cycle;
  - cleared on entry to CPU_OWN.
- CPU_OWN -> DMA_OWN when dma_req & (~cpu_req | wait_cnt == WAIT_MAX-1).
- DMA_OWN -> CPU_OWN when any of these holds:
  - ~dma_req;
  - dma_req & dma_last;
  - dma_req & cpu_req & beat_cnt == BURST_MAX-1.
- If none of these holds, the state stays DMA_OWN.
- A preempted DMA keeps dma_req high. It re-wins only through the CPU_OWN rules above.

## Timing
- Reset values: state = CPU_OWN, wait_cnt = 0, beat_cnt = 0.
  - Outputs: dma_gnt = 0, cpu_stall = 0, dma_err = 0.
  - dm_wr = cpu_req & cpu_wr passes through the same cycle Rst is high. The memory itself clears on Rst.
- Grant latency:
  - dma_req rising with cpu_req low gives dma_gnt high on the next cycle.
  - Worst case with the CPU busy every cycle: WAIT_MAX cycles.
- A beat completes in the cycle dma_req & dma_gnt is high.
  - Write commits at that posedge.
  - dma_rd is valid combinationally in the same cycle.
- A CPU access completes in any cycle with cpu_stall = 0. While stalled, the CPU holds its request stable.
- After the dma_last beat, dma_gnt falls on the next edge. The CPU is served in that cycle.
- Simultaneous dma_last and BURST_MAX-1 preemption give a single transition to CPU_OWN.
- Rst asserted mid-burst: state returns to CPU_OWN at that edge. The in-flight beat still writes if dma_wr was high.

## Test plan
- CPU-only traffic: sw 0x1234_5678 to 0x10, then lw 0x10 -> cpu_rd = 0x1234_5678. cpu_stall stays 0, dma_gnt stays 0.
- DMA burst with CPU idle:
  - dma_req at cycle 0; writes 0xA0..0xA3 to 0x100..0x10C, dma_last on beat 4.
  - Expect dma_gnt high cycles 1-4 and low at cycle 5.
  - Memory words read back as A0..A3.
- Starvation bound, WAIT_MAX = 8: cpu_req held high while dma_req rises at cycle 0 -> dma_gnt rises at cycle 8; cpu_stall = 1 while granted.
- Preemption, BURST_MAX = 4: 10-beat DMA burst with cpu_req high throughout.
  - DMA gets exactly 4 beats, then 1 or more CPU cycles with cpu_stall = 0.
  - DMA regrants after 8 waits; all 10 words written.
- Out of range: DMA write to 0x3000 -> dma_err = 1, dm_wr = 0, memory unchanged. Next beat to 0x2FFC writes normally.
- Reset mid-burst: Rst during beat 2 of 4 -> next cycle dma_gnt = 0, both counters 0, cpu_stall = 0.

Source files
------------

// File: rtl/dm_arbiter.sv
// Two-master arbiter for the shared data-memory port: the pipelined core's M stage
// versus a word-wide DMA/loader that gets bounded bursts and a bounded wait.
module dm_arbiter #(
   parameter int BURST_MAX = 4,
   parameter int WAIT_MAX  = 8,
   parameter int DM_WORDS  = 3072
) (
   input  logic        Clk,
   input  logic        Rst,
   input  logic        cpu_req,
   input  logic        cpu_wr,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wd,
   input  logic [2:0]  cpu_op,
   input  logic [31:0] cpu_wpc,
   output logic [31:0] cpu_rd,
   output logic        cpu_stall,
   input  logic        dma_req,
   input  logic        dma_wr,
   input  logic [31:0] dma_addr,
   input  logic [31:0] dma_wd,
   input  logic        dma_last,
   output logic        dma_gnt,
   output logic [31:0] dma_rd,
   output logic        dma_err,
   output logic        dm_wr,
   output logic [31:0] dm_a,
   output logic [31:0] dm_wd,
   output logic [2:0]  dm_op,
   output logic [31:0] dm_wpc,
   input  logic [31:0] dm_rd
);

   localparam logic [2:0]  DMOP_WORD  = 3'd0;
   localparam logic [31:0] ADDR_LIMIT = 32'(4 * DM_WORDS);
   localparam logic [3:0]  WAIT_LAST  = 4'(WAIT_MAX - 1);
   localparam logic [3:0]  BURST_LAST = 4'(BURST_MAX - 1);

   typedef enum logic [0:0] {
      CPU_OWN = 1'b0,
      DMA_OWN = 1'b1
   } state_t;

   state_t      state_r;
   state_t      state_nxt_s;
   logic [3:0]  wait_cnt_r;
   logic [3:0]  wait_nxt_s;
   logic [3:0]  beat_cnt_r;
   logic [3:0]  beat_nxt_s;
   logic        go_dma_s;
   logic        go_cpu_s;
   logic        dma_err_s;

   function automatic logic addr_out_of_range(input logic [31:0] addr);
      return (addr >= ADDR_LIMIT);
   endfunction

   // Handover conditions: bounded DMA wait and bounded burst under CPU contention
   always_comb begin
      go_dma_s = dma_req & (~cpu_req | (wait_cnt_r == WAIT_LAST));
      go_cpu_s = ~dma_req | dma_last | (cpu_req & (beat_cnt_r == BURST_LAST));
   end

   // Next ownership state
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         CPU_OWN: begin
            if (go_dma_s) begin
               state_nxt_s = DMA_OWN;
            end else begin
               state_nxt_s = CPU_OWN;
            end
         end
         DMA_OWN: begin
            if (go_cpu_s) begin
               state_nxt_s = CPU_OWN;
            end else begin
               state_nxt_s = DMA_OWN;
            end
         end
         default: state_nxt_s = CPU_OWN;
      endcase
   end

   // Next values of the wait and beat counters
   always_comb begin
      wait_nxt_s = 4'd0;
      beat_nxt_s = 4'd0;
      case (state_r)
         CPU_OWN: begin
            if (go_dma_s) begin
               wait_nxt_s = 4'd0;
            end else if (dma_req & cpu_req) begin
               wait_nxt_s = wait_cnt_r + 4'd1;
            end else begin
               wait_nxt_s = 4'd0;
            end
            beat_nxt_s = 4'd0;
         end
         DMA_OWN: begin
            wait_nxt_s = 4'd0;
            if (go_cpu_s) begin
               beat_nxt_s = 4'd0;
            end else if (dma_req) begin
               beat_nxt_s = beat_cnt_r + 4'd1;
            end else begin
               beat_nxt_s = beat_cnt_r;
            end
         end
         default: begin
            wait_nxt_s = 4'd0;
            beat_nxt_s = 4'd0;
         end
      endcase
   end

   // Ownership state and counters; reset wins over an in-flight beat
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_r    <= CPU_OWN;
         wait_cnt_r <= 4'd0;
         beat_cnt_r <= 4'd0;
      end else begin
         state_r    <= state_nxt_s;
         wait_cnt_r <= wait_nxt_s;
         beat_cnt_r <= beat_nxt_s;
      end
   end

   // Out-of-range DMA beats still count as beats but never reach memory
   always_comb begin
      if ((state_r == DMA_OWN) && dma_req) begin
         dma_err_s = addr_out_of_range(dma_addr);
      end else begin
         dma_err_s = 1'b0;
      end
   end

   // Memory port mux and read-data steering
   always_comb begin
      dm_wr     = 1'b0;
      dm_a      = 32'd0;
      dm_wd     = 32'd0;
      dm_op     = DMOP_WORD;
      dm_wpc    = 32'd0;
      cpu_rd    = 32'd0;
      dma_rd    = 32'd0;
      cpu_stall = 1'b0;
      case (state_r)
         CPU_OWN: begin
            dm_wr  = cpu_req & cpu_wr;
            dm_a   = cpu_addr;
            dm_wd  = cpu_wd;
            dm_op  = cpu_op;
            dm_wpc = cpu_wpc;
            cpu_rd = dm_rd;
         end
         DMA_OWN: begin
            dm_wr     = dma_req & dma_wr & ~dma_err_s;
            dm_a      = {dma_addr[31:2], 2'b00};
            dm_wd     = dma_wd;
            dm_op     = DMOP_WORD;
            dm_wpc    = 32'd0;
            dma_rd    = dm_rd;
            cpu_stall = cpu_req;
         end
         default: begin
            dm_wr = 1'b0;
         end
      endcase
   end

   assign dma_gnt = (state_r == DMA_OWN);
   assign dma_err = dma_err_s;

   dm_arbiter_chk #(
      .WAIT_MAX (WAIT_MAX)
   ) u_chk (
      .Clk       (Clk),
      .Rst       (Rst),
      .dma_gnt   (dma_gnt),
      .cpu_stall (cpu_stall),
      .dma_err   (dma_err),
      .dm_wr     (dm_wr),
      .wait_cnt  (wait_cnt_r),
      .beat_cnt  (beat_cnt_r)
   );

endmodule

// Invariants of the arbiter: rejected beats never write, stalls only under DMA
// ownership, and the counters stay inside their operating range.
module dm_arbiter_chk #(
   parameter int WAIT_MAX = 8
) (
   input logic       Clk,
   input logic       Rst,
   input logic       dma_gnt,
   input logic       cpu_stall,
   input logic       dma_err,
   input logic       dm_wr,
   input logic [3:0] wait_cnt,
   input logic [3:0] beat_cnt
);

   a_err_no_write: assert property (@(posedge Clk) disable iff (Rst) !(dma_err && dm_wr));
   a_stall_owned:  assert property (@(posedge Clk) disable iff (Rst) cpu_stall |-> dma_gnt);
   a_wait_bound:   assert property (@(posedge Clk) disable iff (Rst) wait_cnt <= 4'(WAIT_MAX - 1));
   a_beat_idle:    assert property (@(posedge Clk) disable iff (Rst) !dma_gnt |-> (beat_cnt == 4'd0));

endmodule

// File: tb/tb_dm_arbiter.sv
// Scoreboard bench for dm_arbiter: directed cycles push expectations, a negedge
// monitor pops and compares them against the DUT and a bench-side memory.
module tb_dm_arbiter;

   localparam logic [2:0]  CPU_OP  = 3'd1;
   localparam logic [31:0] CPU_WPC = 32'h0040_0100;

   logic        Clk;
   logic        Rst;
   logic        cpu_req, cpu_wr;
   logic [31:0] cpu_addr, cpu_wd, cpu_wpc, cpu_rd;
   logic [2:0]  cpu_op;
   logic        cpu_stall;
   logic        dma_req, dma_wr, dma_last, dma_gnt, dma_err;
   logic [31:0] dma_addr, dma_wd, dma_rd;
   logic        dm_wr;
   logic [31:0] dm_a, dm_wd, dm_wpc, dm_rd;
   logic [2:0]  dm_op;

   logic [31:0] mem [0:3071];

   int passed = 0;
   int total  = 0;

   typedef struct {
      string nm;
      logic  eg;
      logic  es;
      logic  ee;
      logic  ew;
   } exp_t;

   exp_t        ctlq[$];
   logic [31:0] cpu_rdq[$];
   logic [31:0] dma_rdq[$];

   dm_arbiter #(.BURST_MAX(4), .WAIT_MAX(8), .DM_WORDS(3072)) dut (
      .Clk(Clk), .Rst(Rst),
      .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wd(cpu_wd),
      .cpu_op(cpu_op), .cpu_wpc(cpu_wpc), .cpu_rd(cpu_rd), .cpu_stall(cpu_stall),
      .dma_req(dma_req), .dma_wr(dma_wr), .dma_addr(dma_addr), .dma_wd(dma_wd),
      .dma_last(dma_last), .dma_gnt(dma_gnt), .dma_rd(dma_rd), .dma_err(dma_err),
      .dm_wr(dm_wr), .dm_a(dm_a), .dm_wd(dm_wd), .dm_op(dm_op), .dm_wpc(dm_wpc),
      .dm_rd(dm_rd)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // bench-side data memory: combinational read, write at the clock edge
   initial begin
      for (int i = 0; i < 3072; i++) mem[i] = 32'd0;
   end
   assign dm_rd = (dm_a < 32'h3000) ? mem[dm_a[13:2]] : 32'd0;
   always @(posedge Clk) begin
      if (dm_wr && (dm_a < 32'h3000)) mem[dm_a[13:2]] <= dm_wd;
   end

   task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %h expected %h", nm, got, exp);
   endtask

   // monitor: per-cycle control expectations plus completed read transfers
   always @(negedge Clk) begin
      exp_t e;
      if (ctlq.size() > 0) begin
         e = ctlq.pop_front();
         cmp({e.nm, ".dma_gnt"},   {31'd0, dma_gnt},   {31'd0, e.eg});
         cmp({e.nm, ".cpu_stall"}, {31'd0, cpu_stall}, {31'd0, e.es});
         cmp({e.nm, ".dma_err"},   {31'd0, dma_err},   {31'd0, e.ee});
         cmp({e.nm, ".dm_wr"},     {31'd0, dm_wr},     {31'd0, e.ew});
         cmp({e.nm, ".dm_op"},     {29'd0, dm_op},     e.eg ? 32'd0 : {29'd0, CPU_OP});
         cmp({e.nm, ".dm_wpc"},    dm_wpc,             e.eg ? 32'd0 : CPU_WPC);
         if (e.eg) cmp({e.nm, ".cpu_rd_zero"}, cpu_rd, 32'd0);
         else      cmp({e.nm, ".dma_rd_zero"}, dma_rd, 32'd0);
      end
      if (!Rst && cpu_req && !cpu_wr && !cpu_stall) begin
         if (cpu_rdq.size() > 0) cmp("cpu_load", cpu_rd, cpu_rdq.pop_front());
         else cmp("cpu_load_unexpected", 32'd1, 32'd0);
      end
      if (!Rst && dma_req && !dma_wr && dma_gnt) begin
         if (dma_rdq.size() > 0) cmp("dma_read", dma_rd, dma_rdq.pop_front());
         else cmp("dma_read_unexpected", 32'd1, 32'd0);
      end
   end

   // drive one cycle of inputs and queue that cycle's expected control outputs
   task automatic step(input string nm,
                       input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cwd,
                       input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dwd,
                       input logic dl,
                       input logic eg, input logic es, input logic ee, input logic ew);
      exp_t e;
      cpu_req = cr; cpu_wr = cw; cpu_addr = ca; cpu_wd = cwd;
      dma_req = dr; dma_wr = dw; dma_addr = da; dma_wd = dwd; dma_last = dl;
      e.nm = nm; e.eg = eg; e.es = es; e.ee = ee; e.ew = ew;
      ctlq.push_back(e);
      @(posedge Clk);
      #1;
   endtask

   task automatic idle(input string nm);
      step(nm, 0, 0, 32'd0, 32'd0, 0, 0, 32'd0, 32'd0, 0, 0, 0, 0, 0);
   endtask

   task automatic load(input string nm, input logic [31:0] a, input logic [31:0] v);
      cpu_rdq.push_back(v);
      step(nm, 1, 0, a, 32'd0, 0, 0, 32'd0, 32'd0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      logic [31:0] da;
      int beat;
      Rst = 1'b1;
      cpu_op = CPU_OP; cpu_wpc = CPU_WPC;
      cpu_req = 0; cpu_wr = 0; cpu_addr = 0; cpu_wd = 0;
      dma_req = 0; dma_wr = 0; dma_addr = 0; dma_wd = 0; dma_last = 0;
      @(posedge Clk);
      #1;

      // reset: CPU store passes through, a DMA request is not granted
      step("rst_cpu", 1, 1, 32'h20, 32'h55, 0, 0, 32'd0, 32'd0, 0, 0, 0, 0, 1);
      step("rst_dma", 0, 0, 32'd0, 32'd0, 1, 1, 32'h100, 32'h1, 0, 0, 0, 0, 0);
      Rst = 1'b0;
      idle("post_rst");

      // CPU-only traffic
      step("sw", 1, 1, 32'h10, 32'h1234_5678, 0, 0, 32'd0, 32'd0, 0, 0, 0, 0, 1);
      load("lw", 32'h10, 32'h1234_5678);
      idle("cpu_idle");

      // DMA burst with the CPU idle
      step("burst_req", 0, 0, 32'd0, 32'd0, 1, 1, 32'h100, 32'hA0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++)
         step("burst_beat", 0, 0, 32'd0, 32'd0, 1, 1, 32'h100 + 32'(4 * i), 32'hA0 + 32'(i),
              (i == 3), 1, 0, 0, 1);
      idle("burst_end");
      for (int i = 0; i < 4; i++) load("burst_rb", 32'h100 + 32'(4 * i), 32'hA0 + 32'(i));

      // single DMA read beat, low address bits ignored
      dma_rdq.push_back(32'hA1);
      step("dread_req", 0, 0, 32'd0, 32'd0, 1, 0, 32'h107, 32'd0, 1, 0, 0, 0, 0);
      step("dread_beat", 0, 0, 32'd0, 32'd0, 1, 0, 32'h107, 32'd0, 1, 1, 0, 0, 0);
      idle("dread_end");

      // starvation bound: CPU busy every cycle
      for (int k = 0; k < 8; k++)
         step("starve_wait", 1, 1, 32'h800, 32'hDEAD_0000, 1, 1, 32'h200, 32'hB0, 1, 0, 0, 0, 1);
      step("starve_gnt", 1, 1, 32'h800, 32'hDEAD_0000, 1, 1, 32'h200, 32'hB0, 1, 1, 1, 0, 1);
      step("starve_after", 1, 1, 32'h800, 32'hDEAD_0000, 0, 0, 32'd0, 32'd0, 0, 0, 0, 0, 1);
      idle("starve_end");
      load("starve_rb", 32'h200, 32'hB0);

      // preemption: 10-beat burst against a permanently busy CPU -> 4 + 4 + 2 beats
      beat = 0;
      for (int burst = 0; burst < 3; burst++) begin
         for (int w = 0; w < 8; w++) begin
            da = 32'h400 + 32'(4 * beat);
            step("pre_wait", 1, 1, 32'h804, 32'hDEAD_0004, 1, 1, da, 32'hC0 + 32'(beat),
                 (beat == 9), 0, 0, 0, 1);
         end
         for (int k = 0; k < ((burst == 2) ? 2 : 4); k++) begin
            da = 32'h400 + 32'(4 * beat);
            step("pre_beat", 1, 1, 32'h804, 32'hDEAD_0004, 1, 1, da, 32'hC0 + 32'(beat),
                 (beat == 9), 1, 1, 0, 1);
            beat++;
         end
      end
      step("pre_after", 1, 1, 32'h804, 32'hDEAD_0004, 0, 0, 32'd0, 32'd0, 0, 0, 0, 0, 1);
      idle("pre_end");
      for (int i = 0; i < 10; i++) load("pre_rb", 32'h400 + 32'(4 * i), 32'hC0 + 32'(i));
      load("pre_cpu_rb", 32'h804, 32'hDEAD_0004);

      // out-of-range beat is rejected, the next in-range beat writes
      step("oor_req", 0, 0, 32'd0, 32'd0, 1, 1, 32'h3000, 32'hEE, 0, 0, 0, 0, 0);
      step("oor_beat", 0, 0, 32'd0, 32'd0, 1, 1, 32'h3000, 32'hEE, 0, 1, 0, 1, 0);
      step("edge_beat", 0, 0, 32'd0, 32'd0, 1, 1, 32'h2FFC, 32'hEF, 1, 1, 0, 0, 1);
      idle("oor_end");
      load("edge_rb", 32'h2FFC, 32'hEF);

      // reset during the second beat of a 4-beat burst
      step("rmb_req", 0, 0, 32'd0, 32'd0, 1, 1, 32'h600, 32'hD0, 0, 0, 0, 0, 0);
      step("rmb_b0", 0, 0, 32'd0, 32'd0, 1, 1, 32'h600, 32'hD0, 0, 1, 0, 0, 1);
      Rst = 1'b1;
      step("rmb_b1", 0, 0, 32'd0, 32'd0, 1, 1, 32'h604, 32'hD1, 0, 1, 0, 0, 1);
      Rst = 1'b0;
      cmp("rmb_wait_cnt", {28'd0, dut.wait_cnt_r}, 32'd0);
      cmp("rmb_beat_cnt", {28'd0, dut.beat_cnt_r}, 32'd0);
      step("rmb_after", 1, 1, 32'h808, 32'h77, 1, 1, 32'h608, 32'hD2, 0, 0, 0, 0, 1);
      idle("rmb_end");
      load("rmb_rb", 32'h604, 32'hD1);
      idle("final");

      cmp("cpu_rdq_drained", 32'(cpu_rdq.size()), 32'd0);
      cmp("dma_rdq_drained", 32'(dma_rdq.size()), 32'd0);
      cmp("ctlq_drained", 32'(ctlq.size()), 32'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
